// File: rtl/gcd_host_sequencer.sv
// Host-side sequencer for the subtractive GCD engine.
// Serialises operands, waits for done with a timeout, then clears the engine.
module gcd_host_sequencer #(
  parameter int WIDTH        = 16,
  parameter int TIMEOUT      = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_timeout,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_data,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             eng_clear,
  output logic             busy
);

  localparam int WW = $clog2(TIMEOUT);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_SEND_A, S_SEND_B, S_WAIT, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] op_a;
  logic             used_q, used_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             eng_start_q, eng_start_d;
  logic [WIDTH-1:0] eng_data_q, eng_data_d;
  logic             eng_clear_q, eng_clear_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    op_b_d        = op_b_q;
    op_a          = '0;
    used_d        = used_q;
    rsp_gcd_d     = rsp_gcd_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_a   = req_a;
          op_b_d = req_b;
          // A zero operand would never terminate the subtractive engine.
          if (req_a == '0 || req_b == '0) begin
            state_d       = S_RESP;
            rsp_gcd_d     = req_a | req_b;
            rsp_timeout_d = 1'b0;
            used_d        = 1'b0;
          end else begin
            state_d = S_SEND_A;
            used_d  = 1'b1;
          end
        end
      end
      S_SEND_A: state_d = S_SEND_B;
      S_SEND_B: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d       = S_RESP;
          rsp_gcd_d     = eng_result;
          rsp_timeout_d = 1'b0;
        end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
          state_d       = S_RESP;
          rsp_gcd_d     = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d   = used_q ? S_CLEAR : S_IDLE;
          clr_cnt_d = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    eng_start_d = (state_d == S_SEND_A);
    eng_clear_d = (state_d == S_CLEAR);
    busy_d      = (state_d != S_IDLE);
    eng_data_d  = (state_d == S_SEND_A) ? op_a :
                  (state_d == S_SEND_B) ? op_b_q : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      op_b_q        <= '0;
      used_q        <= 1'b0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_gcd_q     <= '0;
      rsp_timeout_q <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_data_q    <= '0;
      eng_clear_q   <= 1'b1;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      op_b_q        <= op_b_d;
      used_q        <= used_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_gcd_q     <= rsp_gcd_d;
      rsp_timeout_q <= rsp_timeout_d;
      eng_start_q   <= eng_start_d;
      eng_data_q    <= eng_data_d;
      eng_clear_q   <= eng_clear_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_gcd     = rsp_gcd_q;
  assign rsp_timeout = rsp_timeout_q;
  assign eng_start   = eng_start_q;
  assign eng_data    = eng_data_q;
  assign eng_clear   = eng_clear_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Directed bench for gcd_host_sequencer with a behavioural GCD engine.
// Engine outputs can be overridden to force timeouts and late done.
module tb_gcd_host_sequencer;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_gcd;
  logic         rsp_timeout;
  logic         eng_start;
  logic [W-1:0] eng_data;
  logic         eng_done;
  logic [W-1:0] eng_result;
  logic         eng_clear;
  logic         busy;

  logic         model_en = 1'b1;
  logic         frc_done = 1'b0;
  logic [W-1:0] frc_res = '0;

  logic [W-1:0] m_x, m_y, m_res;
  logic         m_done, m_ldb, m_run;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int clears = 0;

  always #5 clock = ~clock;

  gcd_host_sequencer #(
    .WIDTH(W), .TIMEOUT(16), .CLEAR_CYCLES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_gcd(rsp_gcd), .rsp_timeout(rsp_timeout),
    .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_result(eng_result),
    .eng_clear(eng_clear), .busy(busy)
  );

  assign eng_done   = model_en ? m_done : frc_done;
  assign eng_result = model_en ? m_res : frc_res;

  always @(posedge clock) begin
    if (eng_clear) begin
      m_done <= 1'b0;
      m_ldb  <= 1'b0;
      m_run  <= 1'b0;
      m_res  <= '0;
    end else if (eng_start) begin
      m_x   <= eng_data;
      m_ldb <= 1'b1;
    end else if (m_ldb) begin
      m_y   <= eng_data;
      m_ldb <= 1'b0;
      m_run <= 1'b1;
    end else if (m_run && !m_done) begin
      if (m_x == m_y) begin
        m_done <= 1'b1;
        m_res  <= m_x;
      end else if (m_x > m_y) begin
        m_x <= m_x - m_y;
      end else begin
        m_y <= m_y - m_x;
      end
    end
  end

  always @(posedge clock) begin
    if (eng_start) starts <= starts + 1;
    if (eng_clear) clears <= clears + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    while (!rsp_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clear"}, eng_clear, 1);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_rdy"}, req_ready, 0);
    check({tag, "_rvld"}, rsp_valid, 0);
    check({tag, "_start"}, eng_start, 0);
    check({tag, "_data"}, eng_data, 0);
    check({tag, "_gcd"}, rsp_gcd, 0);
    check({tag, "_tmo"}, rsp_timeout, 0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int n, s0, c0;
    #2 reset_n = 1'b0;
    #2 check_reset_vals("rst");
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    check("rst_clr1", eng_clear, 1);
    tick();
    check("rst_clr2_done", eng_clear, 0);
    check("rst_idle_rdy", req_ready, 1);
    check("rst_idle_busy", busy, 0);

    // 48/18 through the engine model
    s0 = starts;
    send(16'd48, 16'd18);
    check("a_start", eng_start, 1);
    check("a_data", eng_data, 48);
    check("a_rdy", req_ready, 0);
    tick();
    check("b_start", eng_start, 0);
    check("b_data", eng_data, 18);
    wait_rsp(40, n);
    check("e_rvld", rsp_valid, 1);
    check("e_gcd", rsp_gcd, 6);
    check("e_tmo", rsp_timeout, 0);
    check("e_starts", starts - s0, 1);
    tick();
    check("e_rvld_drop", rsp_valid, 0);
    check("e_clr1", eng_clear, 1);
    tick();
    check("e_clr2", eng_clear, 1);
    tick();
    check("e_clr_end", eng_clear, 0);
    check("e_rdy", req_ready, 1);

    // zero shortcut
    s0 = starts;
    c0 = clears;
    send(16'd0, 16'd35);
    check("z_rvld", rsp_valid, 1);
    check("z_gcd", rsp_gcd, 35);
    check("z_tmo", rsp_timeout, 0);
    tick();
    check("z_rdy", req_ready, 1);
    send(16'd0, 16'd0);
    check("zz_rvld", rsp_valid, 1);
    check("zz_gcd", rsp_gcd, 0);
    tick();
    check("zz_rdy", req_ready, 1);
    check("z_starts", starts - s0, 0);
    check("z_clears", clears - c0, 0);

    // timeout with done stuck low
    model_en = 1'b0;
    frc_done = 1'b0;
    send(16'd7, 16'd3);
    wait_rsp(40, n);
    check("t_lat", n, 18);
    check("t_rvld", rsp_valid, 1);
    check("t_tmo", rsp_timeout, 1);
    check("t_gcd", rsp_gcd, 0);
    tick();
    check("t_clr", eng_clear, 1);
    tick();
    tick();
    check("t_rdy", req_ready, 1);

    // done on the last timeout cycle wins
    frc_res = 16'd5;
    send(16'd10, 16'd5);
    repeat (17) tick();
    check("d_not_yet", rsp_valid, 0);
    frc_done = 1'b1;
    tick();
    check("d_rvld", rsp_valid, 1);
    check("d_gcd", rsp_gcd, 5);
    check("d_tmo", rsp_timeout, 0);
    tick();
    frc_done = 1'b0;
    tick();
    tick();
    check("d_rdy", req_ready, 1);

    // response backpressure with a pending request
    model_en = 1'b1;
    rsp_ready = 1'b0;
    send(16'd48, 16'd18);
    wait_rsp(40, n);
    req_a = 16'd0;
    req_b = 16'd9;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rvld", rsp_valid, 1);
      check("bp_gcd", rsp_gcd, 6);
      check("bp_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_drop", rsp_valid, 0);
    tick();
    tick();
    check("bp_idle_rdy", req_ready, 1);
    check("bp_not_acc", rsp_valid, 0);
    tick();
    req_valid = 1'b0;
    check("bp_acc_rvld", rsp_valid, 1);
    check("bp_acc_gcd", rsp_gcd, 9);
    tick();

    // reset in the middle of WAIT
    model_en = 1'b0;
    frc_done = 1'b0;
    send(16'd7, 16'd3);
    repeat (5) tick();
    check("mr_busy_pre", busy, 1);
    #1 reset_n = 1'b0;
    #1 check_reset_vals("mr");
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    check("mr_clr1", eng_clear, 1);
    check("mr_rvld1", rsp_valid, 0);
    tick();
    check("mr_clr_end", eng_clear, 0);
    check("mr_rvld2", rsp_valid, 0);
    check("mr_rdy", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_host_sequencer.md
Name: gcd_host_sequencer

Overview:
- Initiator-side driver for the subtractive GCD unit (control path plus datapath), which loads operands serially over one shared data bus.
- Accepts operand pairs on a valid/ready request port and drives start and the operand bus with the timing the GCD controller expects: A in the start cycle, B in the next cycle.
- Waits for done with a timeout guard, returns the result on a valid/ready response port, then clears the engine, which otherwise holds its done state indefinitely.
- Short-circuits zero operands, which would hang the subtractive engine.

Parameters:
- WIDTH, 16, operand/result width.
- TIMEOUT, 1024, maximum cycles spent in WAIT before aborting; must be at least 2.
- CLEAR_CYCLES, 2, length of the engine clear pulse; must be at least 1.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request operands valid.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_gcd  out  WIDTH  GCD result; 0 on timeout.
- rsp_timeout  out  1  engine failed to assert done within TIMEOUT cycles.
- eng_start  out  1  start to the GCD controller.
- eng_data  out  WIDTH  shared operand bus to the GCD datapath.
- eng_done  in  1  done from the GCD controller; level, sticky.
- eng_result  in  WIDTH  GCD datapath result register.
- eng_clear  out  1  active-high synchronous clear to the GCD engine.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = CLEAR, clear counter = 0.
  - eng_clear = 1, busy = 1.
  - req_ready, rsp_valid, rsp_timeout, eng_start = 0.
  - rsp_gcd, eng_data = 0.
- After reset deasserts, CLEAR runs its full CLEAR_CYCLES before IDLE, so a freshly powered engine is cleared.
- States: CLEAR, IDLE, SEND_A, SEND_B, WAIT, RESP.
- CLEAR:
  - eng_clear = 1 for exactly CLEAR_CYCLES cycles, then IDLE.
  - req_ready = 0.
- IDLE:
  - req_ready = 1; a request is accepted when req_valid and req_ready are both high at a clock edge.
  - On accept, A and B are latched internally and req_ready drops the next cycle.
  - If A == 0 or B == 0: go to RESP with rsp_gcd = A | B, so (0,0) yields 0; rsp_timeout = 0; engine untouched; no CLEAR afterwards.
  - Otherwise go to SEND_A.
- SEND_A: one cycle, eng_start = 1, eng_data = A.
- SEND_B: one cycle, eng_start = 0, eng_data = B. The controller loads A on the edge ending SEND_A and B on the edge ending SEND_B.
- WAIT:
  - eng_data = 0; the wait counter starts at 0 on entry and increments every cycle.
  - If eng_done is sampled high: rsp_gcd = eng_result, rsp_timeout = 0, go to RESP.
  - Else, when the counter reaches TIMEOUT-1: rsp_gcd = 0, rsp_timeout = 1, go to RESP.
  - If done and the last timeout cycle coincide, done wins.
- RESP:
  - rsp_valid = 1; rsp_gcd and rsp_timeout stay stable until the rsp_valid/rsp_ready handshake.
  - On handshake, rsp_valid drops the next cycle.
  - Next state is CLEAR if the engine was used, including after a timeout; otherwise IDLE.
- Backpressure: there is no request queue. req_ready stays 0 in every state except IDLE.
- Reset mid-operation:
  - Immediately returns all outputs to their reset values.
  - The in-flight request is discarded and no response is issued.
  - The engine is cleared by the following CLEAR sequence.
- Latency, accept edge to rsp_valid:
  - zero shortcut: 1 cycle.
  - engine path: 2 + k + 1 cycles, where k is the number of WAIT cycles until done is sampled.

Test Plan:
- Reset then A=48, B=18 with the engine model: exactly one eng_start pulse with eng_data=48; eng_data=18 the next cycle; rsp_gcd=6, rsp_timeout=0; then eng_clear high for 2 cycles; req_ready=1 again.
- A=0, B=35: rsp_valid 1 cycle after accept with rsp_gcd=35; eng_start and eng_clear never assert. A=0, B=0 gives rsp_gcd=0.
- TIMEOUT=16, eng_done tied 0, A=7, B=3: rsp_valid with rsp_timeout=1 and rsp_gcd=0 after 16 WAIT cycles; CLEAR follows.
- eng_done rises on WAIT cycle 15 with TIMEOUT=16 and eng_result=5: rsp_gcd=5, rsp_timeout=0.
- Hold rsp_ready=0 for 5 cycles on the 48/18 request: rsp_valid, rsp_gcd=6 and req_ready=0 stay stable throughout. A second req_valid during this time is not accepted until IDLE.
- Assert reset_n=0 mid-WAIT: all outputs take reset values asynchronously; after release, eng_clear is high for 2 cycles, no rsp_valid appears, then req_ready=1.
